// File: rtl/decimal_display_driver_pkg.sv
// Shared types and constants for the decimal display driver: FSM states,
// 4-bit digit codes and 7-segment patterns ({g,f,e,d,c,b,a}, active-high).
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } state_t;

    // Codes 0..9 are the decimal digits themselves; the two extra codes
    // cover the sign position and blanked leading zeros.
    localparam logic [3:0] DIG_ZERO  = 4'h0;
    localparam logic [3:0] DIG_MINUS = 4'hA;
    localparam logic [3:0] DIG_BLANK = 4'hF;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/decimal_display_driver_if.sv
// Handshake between the OUT register (master) and the display driver (slave).
interface decimal_display_driver_if #(
    parameter int N = 8
) ();

    logic [N-1:0] value;
    logic         load;
    logic         signed_mode;
    logic         busy;

    modport master (
        output value,
        output load,
        output signed_mode,
        input  busy
    );

    modport slave (
        input  value,
        input  load,
        input  signed_mode,
        output busy
    );

endinterface

// File: rtl/decimal_display_driver_seg7_decode.sv
// Combinational digit-code to 7-segment pattern decoder (active-high segments).
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_BLANK;
        case (code)
            4'd0:      pattern = SEG_0;
            4'd1:      pattern = SEG_1;
            4'd2:      pattern = SEG_2;
            4'd3:      pattern = SEG_3;
            4'd4:      pattern = SEG_4;
            4'd5:      pattern = SEG_5;
            4'd6:      pattern = SEG_6;
            4'd7:      pattern = SEG_7;
            4'd8:      pattern = SEG_8;
            4'd9:      pattern = SEG_9;
            DIG_MINUS: pattern = SEG_MINUS;
            default:   pattern = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/decimal_display_driver.sv
// Shows the OUT register value in decimal on a multiplexed 7-segment display:
// iterative double-dabble conversion into a shadow, plus a free-running scan.
module decimal_display_driver
    import display_pkg::*;
#(
    parameter int N           = 8,
    parameter int DIGITS      = 4,
    parameter int SCAN_DIV    = 1024,
    parameter bit SEG_ACT_LOW = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst,
    decimal_display_driver_if.slave  bus,
    output logic [6:0]               seg,
    output logic [DIGITS-1:0]        digit_en
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(N + 1);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    state_t          state, state_next;
    logic [N-1:0]    mag;
    logic [N-1:0]    mag_in;
    logic [BW-1:0]   bcd;
    logic [BW-1:0]   bcd_adj;
    logic [CW-1:0]   cnt;
    logic            neg;
    logic            neg_in;
    logic [3:0]      shadow      [DIGITS];
    logic [3:0]      commit_code [DIGITS];
    int              msd;
    logic [IW-1:0]   scan_idx;
    logic [PW-1:0]   presc;
    logic [6:0]      scan_pattern;

    // N-bit negation of -2^(N-1) wraps to 2^(N-1), which is exactly the
    // required magnitude when read as unsigned, so no extra bit is kept.
    assign neg_in = bus.signed_mode & bus.value[N-1];
    assign mag_in = neg_in ? (~bus.value + N'(1)) : bus.value;

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.load) state_next = CONVERT;
            CONVERT: if (cnt == CW'(1)) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Blank everything above the most-significant nonzero digit, keeping
    // digit0 so zero still reads "0"; the sign sits just left of it.
    always_comb begin
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] != DIG_ZERO) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= msd)                    commit_code[i] = bcd[4*i +: 4];
            else if (neg && (i == msd + 1))  commit_code[i] = DIG_MINUS;
            else                             commit_code[i] = DIG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag <= '0;
            bcd <= '0;
            cnt <= '0;
            neg <= 1'b0;
            for (int i = 0; i < DIGITS; i++) shadow[i] <= DIG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        mag <= mag_in;
                        neg <= neg_in;
                        bcd <= '0;
                        cnt <= CW'(N);
                    end
                end
                CONVERT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    cnt        <= cnt - CW'(1);
                end
                COMMIT: begin
                    for (int i = 0; i < DIGITS; i++) shadow[i] <= commit_code[i];
                end
                default: ;
            endcase
        end
    end

    seg7_decode u_decode (
        .code    (shadow[scan_idx]),
        .pattern (scan_pattern)
    );

    // digit_en and seg come from the same index on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc    <= '0;
            scan_idx <= '0;
            seg      <= {7{SEG_ACT_LOW}};
            digit_en <= '0;
        end else begin
            if (presc == PW'(SCAN_DIV - 1)) begin
                presc    <= '0;
                scan_idx <= (scan_idx == IW'(DIGITS - 1)) ? '0 : scan_idx + IW'(1);
            end else begin
                presc <= presc + PW'(1);
            end
            digit_en <= DIGITS'(1) << scan_idx;
            seg      <= scan_pattern ^ {7{SEG_ACT_LOW}};
        end
    end

endmodule
